// File: rtl/y86_alu_pkg.sv
// Shared constants for the Y86-64 execute-stage ALU: op encodings, flag indices,
// condition function codes and the condition-code reset value.
package y86_alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam logic [2:0] CC_RESET = 3'b100;

  // Signed "less than" as seen by the flags: sign disagrees with overflow.
  function automatic logic cc_lt(input logic [2:0] cc);
    return cc[CC_SF] ^ cc[CC_OF];
  endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Evaluates a jXX/cmovXX condition function against the registered condition codes.
module y86_cond_eval
  import y86_alu_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] fun,
  output logic       cnd
);

  logic w_zf;
  logic w_lt;

  assign w_zf = cc[CC_ZF];
  assign w_lt = cc_lt(cc);

  always_comb begin
    cnd = 1'b0;
    case (fun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = w_lt | w_zf;
      C_L:      cnd = w_lt;
      C_E:      cnd = w_zf;
      C_NE:     cnd = ~w_zf;
      C_GE:     cnd = ~w_lt;
      C_G:      cnd = ~w_lt & ~w_zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_alu.sv
// Y86-64 execute-stage ALU with architectural condition-code register.
// Optional Y86_ALU_COND_EVAL_EN adds the fun input and cnd output (condition evaluation on cc).
module y86_alu
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  input  logic             set_cc,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cond,
  output logic [2:0]       cc
`ifdef Y86_ALU_COND_EVAL_EN
  ,
  input  logic [3:0]       fun,
  output logic             cnd
`endif
);

  // No handshake: result/cond follow a/b/ctrl combinationally; cc loads cond
  // on a rising edge only when set_cc is high and reset_n is released.

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_r_msb;
  logic             w_of;
  logic [2:0]       r_cc;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    w_result = w_sum;
    case (ctrl)
      ALU_ADD: w_result = w_sum;
      ALU_SUB: w_result = w_diff;
      ALU_AND: w_result = a & b;
      ALU_XOR: w_result = a ^ b;
      default: w_result = w_sum;
    endcase
  end

  assign w_a_msb = a[WIDTH-1];
  assign w_b_msb = b[WIDTH-1];
  assign w_r_msb = w_result[WIDTH-1];

  // Overflow only when the result sign departs from a's sign under a
  // sign relationship of the operands that makes that impossible otherwise.
  always_comb begin
    w_of = 1'b0;
    case (ctrl)
      ALU_ADD: w_of = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
      ALU_SUB: w_of = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
      default: w_of = 1'b0;
    endcase
  end

  always_comb begin
    cond        = 3'b000;
    cond[CC_ZF] = (w_result == '0);
    cond[CC_SF] = w_r_msb;
    cond[CC_OF] = w_of;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cc <= CC_RESET;
    end else if (set_cc) begin
      r_cc <= cond;
    end
  end

  assign result = w_result;
  assign cc     = r_cc;

`ifdef Y86_ALU_COND_EVAL_EN
  y86_cond_eval u_cond_eval (
    .cc  (r_cc),
    .fun (fun),
    .cnd (cnd)
  );
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: driver pushes expected {result, cond, cc, cnd}
// computed from signed arithmetic; a negedge monitor pops and compares.
module tb_y86_alu;

  localparam int W  = 64;
  localparam int EW = W + 3 + 3 + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   ctrl = 2'b00;
  logic         set_cc = 1'b0;
  logic [W-1:0] result;
  logic [2:0]   cond;
  logic [2:0]   cc;
  logic [3:0]   fun = 4'd0;
  logic         cnd_obs;

`ifdef Y86_ALU_COND_EVAL_EN
  logic cnd;
  assign cnd_obs = cnd;
`else
  assign cnd_obs = 1'b0;
`endif

  y86_alu #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ctrl    (ctrl),
    .set_cc  (set_cc),
    .result  (result),
    .cond    (cond),
    .cc      (cc)
`ifdef Y86_ALU_COND_EVAL_EN
    ,
    .fun     (fun),
    .cnd     (cnd)
`endif
  );

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [2:0]    model_cc = 3'b100;
  logic [2:0]    cur_cond = 3'b000;

  // Exact signed arithmetic; overflow means the true value does not fit in W bits.
  function automatic void ref_alu(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic [1:0] ic,
                                  output logic [W-1:0] res, output logic [2:0] fl);
    logic signed [W+1:0] sa, sb, wide;
    logic of;
    sa = $signed({{2{ia[W-1]}}, ia});
    sb = $signed({{2{ib[W-1]}}, ib});
    of = 1'b0;
    case (ic)
      2'd0: begin wide = sa + sb; res = wide[W-1:0]; of = (wide != $signed({{2{res[W-1]}}, res})); end
      2'd1: begin wide = sa - sb; res = wide[W-1:0]; of = (wide != $signed({{2{res[W-1]}}, res})); end
      2'd2: res = ia & ib;
      default: res = ia ^ ib;
    endcase
    fl = {res == '0, $signed(res) < 0, of};
  endfunction

  function automatic logic ref_cnd(input logic [2:0] c, input logic [3:0] f);
    logic zf, lt;
    zf = c[2];
    lt = (c[1] != c[0]);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [1:0] ic, input logic is, input logic [3:0] ifn,
                      input logic irst);
    logic [W-1:0] res;
    logic [2:0]   fl;
    @(posedge clock);
    if (reset_n && set_cc) model_cc = cur_cond;
    #1;
    reset_n = irst;
    if (!irst) model_cc = 3'b100;
    a = ia; b = ib; ctrl = ic; set_cc = is; fun = ifn;
    ref_alu(ia, ib, ic, res, fl);
    cur_cond = fl;
    exp_q.push_back({res, fl, model_cc, ref_cnd(model_cc, ifn)});
    n_vec++;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return '0;
      3: return '1;
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (result !== e[EW-1 -: W]) begin
        n_miss++;
        $display("FAIL result: got %h expected %h (a=%h b=%h ctrl=%0d)", result, e[EW-1 -: W], a, b, ctrl);
      end
      if (cond !== e[6:4]) begin
        n_miss++;
        $display("FAIL cond: got %b expected %b (a=%h b=%h ctrl=%0d)", cond, e[6:4], a, b, ctrl);
      end
      if (cc !== e[3:1]) begin
        n_miss++;
        $display("FAIL cc: got %b expected %b", cc, e[3:1]);
      end
`ifdef Y86_ALU_COND_EVAL_EN
      if (cnd_obs !== e[0]) begin
        n_miss++;
        $display("FAIL cnd: got %b expected %b (cc=%b fun=%0d)", cnd_obs, e[0], cc, fun);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state, held over a clock edge with set_cc requested
    step(64'd5, 64'd7, 2'd0, 1'b1, 4'd3, 1'b0);
    step(64'd5, 64'd7, 2'd0, 1'b0, 4'd3, 1'b1);
    // directed arithmetic and logic cases
    step(64'd5, 64'd7, 2'd0, 1'b0, 4'd0, 1'b1);
    step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b0, 4'd1, 1'b1);
    step(64'd3, 64'd3, 2'd1, 1'b0, 4'd4, 1'b1);
    step(64'h8000_0000_0000_0000, 64'd1, 2'd1, 1'b0, 4'd5, 1'b1);
    step(64'd0, 64'd0, 2'd1, 1'b0, 4'd6, 1'b1);
    step(64'hF0, 64'h0F, 2'd2, 1'b0, 4'd9, 1'b1);
    step(64'hF0, 64'h0F, 2'd3, 1'b0, 4'd2, 1'b1);
    step('1, 64'd1, 2'd3, 1'b0, 4'd0, 1'b1);
    // cc gating: load 010, then change inputs with set_cc low
    step(64'd2, 64'd5, 2'd1, 1'b1, 4'd0, 1'b1);
    for (int f = 0; f < 16; f++) step(64'd9, 64'd9, 2'd1, 1'b0, 4'(f), 1'b1);
    // async reset between edges, with a pending load that must be dropped
    step(64'd9, 64'd1, 2'd1, 1'b1, 4'd3, 1'b0);
    step(64'd9, 64'd1, 2'd1, 1'b0, 4'd3, 1'b1);
    for (int f = 0; f < 16; f++) step(64'd4, 64'd1, 2'd0, 1'b0, 4'(f), 1'b1);
    // randomized
    for (int i = 0; i < 600; i++)
      step(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), (i % 97 == 96) ? 1'b0 : 1'b1);
    @(posedge clock);
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
